bcd2bin: RTL



---
 rtl/bcd2bin_pkg.sv | 23 ++
 rtl/bcd2bin_digit_adj.sv | 18 +
 rtl/bcd2bin.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/bcd2bin_pkg.sv
// Shared definitions for the BCD-to-binary converter.
//   state_t      : controller states (IDLE / OP / DONE)
//   ADJ_THRESH   : digit value at which the reverse double-dabble correction applies
//   ADJ_OFFSET   : amount subtracted from a corrected digit
//   MAX_DIGIT    : largest legal BCD digit
//   digit_bad()  : flags a 4-bit digit that is not a legal BCD value
package bcd2bin_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OP   = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam logic [3:0] ADJ_THRESH = 4'd8;
   localparam logic [3:0] ADJ_OFFSET = 4'd3;
   localparam logic [3:0] MAX_DIGIT  = 4'd9;

   function automatic logic digit_bad(input logic [3:0] d);
      return (d > MAX_DIGIT);
   endfunction

endpackage

// File: rtl/bcd2bin_digit_adj.sv
// Combinational per-digit correction cell for reverse double-dabble.
//   i_digit : digit after the right shift
//   o_digit : i_digit - 3 when i_digit >= 8, otherwise i_digit unchanged
module bcd_digit_adj
   import bcd2bin_pkg::*;
(
   input  logic [3:0] i_digit,
   output logic [3:0] o_digit
);

   always_comb begin
      o_digit = i_digit;
      if (i_digit >= ADJ_THRESH) begin
         o_digit = i_digit - ADJ_OFFSET;
      end
   end

endmodule

// File: rtl/bcd2bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one shift per clock.
// Result is sign-magnitude; magnitude saturates on overflow, clears on illegal digits.
//   clk       : system clock
//   reset     : synchronous, active-high
//   start     : request a conversion, sampled only while ready=1
//   sign      : input sign, 1 = negative
//   bcd       : packed BCD digits, digit 0 at bits [3:0]
//   ready     : high in IDLE
//   done_tick : one-cycle pulse in the cycle bin/err/ovf take their new value
//   bin       : {sign, magnitude}, held until the next conversion completes
//   err       : last conversion contained a digit above 9
//   ovf       : last magnitude did not fit in BIN_N-1 bits
module bcd2bin
   import bcd2bin_pkg::*;
#(
   parameter int BCD_N = 4,
   parameter int BIN_N = 14
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 sign,
   input  logic [4*BCD_N-1:0]   bcd,
   output logic                 ready,
   output logic                 done_tick,
   output logic [BIN_N-1:0]     bin,
   output logic                 err,
   output logic                 ovf
);

   localparam int W   = 4 * BCD_N;
   localparam int MAG = BIN_N - 1;
   localparam int CW  = $clog2(W + 1);
   // 2^MAG held one bit wider than acc so MAG == W still compares correctly
   localparam logic [W:0] LIM = {{W{1'b0}}, 1'b1} << MAG;

   state_t           r_state;
   state_t           w_state_next;

   logic [W-1:0]     r_bcd;
   logic [W-1:0]     r_acc;
   logic [CW-1:0]    r_n;
   logic             r_sign;
   logic             r_err_in;
   logic [BIN_N-1:0] r_bin;
   logic             r_err;
   logic             r_ovf;

   logic [W-1:0]     w_bcd_sh;
   logic [W-1:0]     w_bcd_adj;
   logic [W-1:0]     w_acc_sh;
   logic             w_bad_in;
   logic             w_last;
   logic             w_ovf_det;
   logic [MAG-1:0]   w_mag;
   logic [BIN_N-1:0] w_bin_fin;

   // Shift {bcd, acc} right by one; bcd LSB feeds acc MSB
   assign w_bcd_sh = {1'b0, r_bcd[W-1:1]};
   assign w_acc_sh = {r_bcd[0], r_acc[W-1:1]};

   for (genvar g = 0; g < BCD_N; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .i_digit (w_bcd_sh[4*g +: 4]),
         .o_digit (w_bcd_adj[4*g +: 4])
      );
   end

   always_comb begin
      w_bad_in = 1'b0;
      for (int unsigned i = 0; i < BCD_N; i++) begin
         if (digit_bad(bcd[4*i +: 4])) begin
            w_bad_in = 1'b1;
         end
      end
   end

   // Final result is formed from the last shifted acc so it lands together with DONE
   assign w_last    = (r_state == OP) && (r_n == CW'(1));
   assign w_ovf_det = ({1'b0, w_acc_sh} >= LIM);

   always_comb begin
      w_mag = w_acc_sh[MAG-1:0];
      if (r_err_in) begin
         w_mag = '0;
      end else if (w_ovf_det) begin
         w_mag = '1;
      end
   end

   // Negative zero is reported as +0
   assign w_bin_fin = {r_sign & (|w_mag), w_mag};

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start) w_state_next = OP;
         OP:      if (r_n == CW'(1)) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      ready     = 1'b0;
      done_tick = 1'b0;
      case (r_state)
         IDLE:    ready     = 1'b1;
         DONE:    done_tick = 1'b1;
         default: ;
      endcase
   end

   // Datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bcd    <= '0;
         r_acc    <= '0;
         r_n      <= '0;
         r_sign   <= 1'b0;
         r_err_in <= 1'b0;
         r_bin    <= '0;
         r_err    <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_bcd    <= bcd;
                  r_sign   <= sign;
                  r_acc    <= '0;
                  r_n      <= CW'(W);
                  r_err_in <= w_bad_in;
               end
            end
            OP: begin
               r_bcd <= w_bcd_adj;
               r_acc <= w_acc_sh;
               r_n   <= r_n - CW'(1);
               if (w_last) begin
                  r_bin <= w_bin_fin;
                  r_err <= r_err_in;
                  r_ovf <= ~r_err_in & w_ovf_det;
               end
            end
            default: ;
         endcase
      end
   end

   assign bin = r_bin;
   assign err = r_err;
   assign ovf = r_ovf;

endmodule
